// File: rtl/spmm_pkg.sv
// -----------------------------------------------------------------------------
// spmm_pkg
// Shared constants and types for the SpMM output drain.
//   N, W, LANES : tile dimension, element width, rows per output beat
//   LG_N        : bits of a row index within a tile
//   DB_LG_N     : bits of a drain beat index (N/LANES beats per tile)
//   row_t       : one tile row of N elements
//   beat_t      : one output beat of LANES rows
//   bank_state_t: lifecycle of a ping-pong bank
// -----------------------------------------------------------------------------
package spmm_pkg;

   localparam int N       = 16;
   localparam int W       = 8;
   localparam int LANES   = 4;
   localparam int LG_N    = $clog2(N);
   localparam int BEATS   = N / LANES;
   localparam int DB_LG_N = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef logic [W-1:0]       data_t;
   typedef data_t [N-1:0]      row_t;
   typedef row_t [LANES-1:0]   beat_t;
   typedef logic [LG_N-1:0]    row_idx_t;
   typedef logic [DB_LG_N-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL,
      DRAINING
   } bank_state_t;

   // Elementwise add, each element wrapping modulo 2^W.
   function automatic row_t row_add(row_t a, row_t b);
      row_t s;
      for (int e = 0; e < N; e++) begin
         s[e] = a[e] + b[e];
      end
      return s;
   endfunction

endpackage

// File: rtl/spmm_out_drain_if.sv
// -----------------------------------------------------------------------------
// spmm_out_drain_if
// Row-write and tile-drain handshake of the SpMM output drain.
//   wr_valid/wr_ready/wr_row/wr_acc/wr_last/wr_data : result-row write port
//   out_ready/out_start/out_valid/out_data          : tile drain port
// Modports: master = PE array + downstream consumer, slave = drain block.
// -----------------------------------------------------------------------------
interface spmm_out_drain_if;
   import spmm_pkg::*;

   logic     wr_valid;
   logic     wr_ready;
   row_idx_t wr_row;
   logic     wr_acc;
   logic     wr_last;
   row_t     wr_data;
   logic     out_ready;
   logic     out_start;
   logic     out_valid;
   beat_t    out_data;

   modport master (
      output wr_valid, wr_row, wr_acc, wr_last, wr_data, out_start,
      input  wr_ready, out_ready, out_valid, out_data
   );

   modport slave (
      input  wr_valid, wr_row, wr_acc, wr_last, wr_data, out_start,
      output wr_ready, out_ready, out_valid, out_data
   );

endinterface

// File: rtl/spmm_out_bank.sv
// -----------------------------------------------------------------------------
// spmm_out_bank
// One N x N result bank with a per-row written mask.
//   i_clock, i_reset : clock, synchronous active-low reset (clears mask only)
//   i_wr_en          : write the row addressed by i_wr_row
//   i_wr_acc         : add i_wr_data to the stored row instead of overwriting
//   i_wr_data        : row to store / accumulate
//   i_mask_clr       : forget every row (bank is being released)
//   i_rd_beat        : beat index; reads rows LANES*beat .. LANES*beat+LANES-1
//   o_rd_data        : those rows, unwritten rows forced to 0
// -----------------------------------------------------------------------------
module spmm_out_bank
   import spmm_pkg::*;
(
   input  logic      i_clock,
   input  logic      i_reset,
   input  logic      i_wr_en,
   input  row_idx_t  i_wr_row,
   input  logic      i_wr_acc,
   input  row_t      i_wr_data,
   input  logic      i_mask_clr,
   input  beat_idx_t i_rd_beat,
   output beat_t     o_rd_data
);

   row_t           r_mem [N];
   logic [N-1:0]   r_mask;

   // NOTE: the data array has no reset; the mask alone decides whether a row
   // holds tile data, so stale contents are never observed.
   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         // An accumulate onto a row not yet written this tile is a plain store.
         r_mem[i_wr_row] <= (i_wr_acc && r_mask[i_wr_row])
                            ? row_add(r_mem[i_wr_row], i_wr_data)
                            : i_wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_mask <= '0;
      end else if (i_mask_clr) begin
         r_mask <= '0;
      end else if (i_wr_en) begin
         r_mask[i_wr_row] <= 1'b1;
      end
   end

   // NOTE: the output gets a full default before the loop so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (r_mask[row_idx_t'(LANES * int'(i_rd_beat) + i)]) begin
            o_rd_data[i] = r_mem[row_idx_t'(LANES * int'(i_rd_beat) + i)];
         end
      end
   end

endmodule

// File: rtl/spmm_out_drain.sv
// -----------------------------------------------------------------------------
// spmm_out_drain
// Collects PE result rows into a ping-pong pair of banks (with optional
// in-place accumulation) and streams each completed tile out LANES rows per
// beat over N/LANES beats.
//   i_clock : clock
//   i_reset : synchronous active-low reset
//   bus     : spmm_out_drain_if.slave (write port + drain port)
// wb selects the bank being filled, rb the bank next to be drained.
// -----------------------------------------------------------------------------
module spmm_out_drain
   import spmm_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset,
   spmm_out_drain_if.slave  bus
);

   bank_state_t r_state [2];
   logic        r_wb;
   logic        r_rb;
   beat_idx_t   r_beat;
   logic        r_out_valid;
   beat_t       r_out_data;

   logic        w_wr_ready;
   logic        w_out_ready;
   logic        w_wr_fire;
   logic        w_start;
   logic        w_draining;
   logic        w_last_beat;
   beat_idx_t   w_rd_beat;
   beat_t       w_rd_data [2];

   // Both handshakes decode registered bank state only.
   assign w_wr_ready  = (r_state[r_wb] == EMPTY) || (r_state[r_wb] == FILLING);
   assign w_out_ready = (r_state[r_rb] == FULL);
   assign w_wr_fire   = bus.wr_valid && w_wr_ready;
   assign w_start     = bus.out_start && w_out_ready;
   assign w_draining  = (r_state[r_rb] == DRAINING);
   assign w_last_beat = w_draining && (r_beat == beat_idx_t'(BEATS - 1));

   // Output data is registered, so read one beat ahead: beat 0 at the start
   // edge, beat k+1 while beat k is on the bus.
   assign w_rd_beat   = w_draining ? r_beat + beat_idx_t'(1) : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      spmm_out_bank u_bank (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_wr_en   (w_wr_fire && (r_wb == 1'(b))),
         .i_wr_row  (bus.wr_row),
         .i_wr_acc  (bus.wr_acc),
         .i_wr_data (bus.wr_data),
         .i_mask_clr(w_last_beat && (r_rb == 1'(b))),
         .i_rd_beat (w_rd_beat),
         .o_rd_data (w_rd_data[b])
      );
   end

   // Writes only touch a bank that is EMPTY/FILLING and the drain only one
   // that is FULL/DRAINING, so the two updates below never target the same
   // bank state in one cycle.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state[0]  <= EMPTY;
         r_state[1]  <= EMPTY;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_last_beat) begin
            r_state[r_rb] <= EMPTY;
            r_rb          <= ~r_rb;
            r_beat        <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
         end else if (w_draining) begin
            r_beat        <= r_beat + beat_idx_t'(1);
            r_out_data    <= w_rd_data[r_rb];
         end else if (w_start) begin
            r_state[r_rb] <= DRAINING;
            r_beat        <= '0;
            r_out_valid   <= 1'b1;
            r_out_data    <= w_rd_data[r_rb];
         end

         if (w_wr_fire) begin
            r_state[r_wb] <= bus.wr_last ? FULL : FILLING;
            if (bus.wr_last) begin
               r_wb <= ~r_wb;
            end
         end
      end
   end

   assign bus.wr_ready  = w_wr_ready;
   assign bus.out_ready = w_out_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_spmm_out_drain.sv
// -----------------------------------------------------------------------------
// tb_spmm_out_drain
// Self-checking bench for spmm_out_drain. A tile-queue model tracks completed
// tiles; a negedge process compares every handshake/output against it, and
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_spmm_out_drain;
   import spmm_pkg::*;

   typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spmm_out_drain_if bus ();

   spmm_out_drain dut (
      .i_clock(clk),
      .i_reset(rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string name, logic [511:0] got, logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_q holds completed tiles not yet released (FULL or being drained),
   // oldest first; the head is the one drained next.
   tile_t        m_q [$];
   tile_t        m_fill;
   logic [N-1:0] m_written;
   bit           m_init = 0;
   bit           m_drn;
   int           m_beat;
   bit           m_ev;
   beat_t        m_ed;

   function automatic beat_t beat_of(tile_t t, int k);
      beat_t b;
      for (int i = 0; i < LANES; i++) b[i] = t[LANES * k + i];
      return b;
   endfunction

   always @(posedge clk) begin
      bit wr_rdy;
      bit o_rdy;
      int row;
      if (!rst_n) begin
         m_q.delete();
         m_fill    = '0;
         m_written = '0;
         m_drn     = 0;
         m_beat    = 0;
         m_ev      = 0;
         m_ed      = '0;
         m_init    = 1;
      end else if (m_init) begin
         wr_rdy = (m_q.size() < 2);
         o_rdy  = (m_q.size() > 0) && !m_drn;
         if (m_drn) begin
            if (m_beat == BEATS - 1) begin
               void'(m_q.pop_front());
               m_drn = 0;
               m_ev  = 0;
               m_ed  = '0;
            end else begin
               m_beat++;
               m_ed = beat_of(m_q[0], m_beat);
            end
         end else if (bus.out_start && o_rdy) begin
            m_drn  = 1;
            m_beat = 0;
            m_ev   = 1;
            m_ed   = beat_of(m_q[0], 0);
         end
         if (bus.wr_valid && wr_rdy) begin
            row = int'(bus.wr_row);
            for (int e = 0; e < N; e++) begin
               data_t base;
               base = (bus.wr_acc && m_written[row]) ? m_fill[row][e] : '0;
               m_fill[row][e] = data_t'(base + bus.wr_data[e]);
            end
            m_written[row] = 1'b1;
            if (bus.wr_last) begin
               m_q.push_back(m_fill);
               m_fill    = '0;
               m_written = '0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("wr_ready",  bus.wr_ready,  (m_q.size() < 2));
         check("out_ready", bus.out_ready, (m_q.size() > 0) && !m_drn);
         check("out_valid", bus.out_valid, m_ev);
         check("out_data",  bus.out_data,  m_ed);
      end
   end

   // Beats seen on the bus, for the literal expectations.
   beat_t cap [$];
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) cap.push_back(bus.out_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic row_t splat(int v);
      row_t r;
      for (int e = 0; e < N; e++) r[e] = data_t'(v);
      return r;
   endfunction

   task automatic wr(int row, bit acc, bit last, row_t d);
      bus.wr_valid = 1'b1;
      bus.wr_row   = row_idx_t'(row);
      bus.wr_acc   = acc;
      bus.wr_last  = last;
      bus.wr_data  = d;
      tick();
      bus.wr_valid = 1'b0;
      bus.wr_last  = 1'b0;
      bus.wr_acc   = 1'b0;
   endtask

   // Pulse out_start for one cycle, then wait out the beats plus one cycle.
   task automatic drain();
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      repeat (BEATS + 1) tick();
   endtask

   task automatic fill_tile(int base);
      for (int r = 0; r < N; r++) wr(r, 1'b0, r == N - 1, splat(base + r));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n         = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_row    = '0;
      bus.wr_acc    = 1'b0;
      bus.wr_last   = 1'b0;
      bus.wr_data   = '0;
      bus.out_start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;

      // Reset values
      check("rst_wr_ready",  bus.wr_ready,  1'b1);
      check("rst_out_ready", bus.out_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data",  bus.out_data,  '0);

      // Single tile: row r holds r+1 everywhere
      fill_tile(1);
      check("t1_out_ready_next", bus.out_ready, 1'b1);
      cap.delete();
      drain();
      check("t1_beats", cap.size(), 4);
      for (int k = 0; k < BEATS; k++)
         for (int i = 0; i < LANES; i++)
            if (cap.size() == BEATS)
               check($sformatf("t1_b%0d_l%0d", k, i), cap[k][i], splat(4 * k + i + 1));
      check("t1_out_ready_after", bus.out_ready, 1'b0);

      // Accumulate: 10+250 wraps to 4; acc onto unwritten row is a store
      wr(3, 1'b0, 1'b0, splat(10));
      wr(3, 1'b1, 1'b0, splat(250));
      wr(5, 1'b1, 1'b0, splat(7));
      wr(0, 1'b0, 1'b1, splat(1));
      cap.delete();
      drain();
      check("acc_beats", cap.size(), 4);
      if (cap.size() == BEATS) begin
         check("acc_row3", cap[0][3], splat(4));
         check("acc_row5", cap[1][1], splat(7));
         check("acc_row9", cap[2][1], '0);
      end

      // Ping-pong: drain A while filling B, third tile blocked until A frees
      fill_tile(8'h40);
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      wr(0, 1'b0, 1'b0, splat(8'h80));
      wr(1, 1'b0, 1'b0, splat(8'h81));
      wr(2, 1'b0, 1'b1, splat(8'h82));
      check("pp_blocked",   bus.wr_ready,  1'b0);
      check("pp_last_beat", bus.out_valid, 1'b1);
      bus.wr_valid = 1'b1;
      bus.wr_row   = '0;
      bus.wr_acc   = 1'b1;
      bus.wr_data  = splat(5);
      tick();
      check("pp_wr_reopen",  bus.wr_ready,  1'b1);
      check("pp_out_ready",  bus.out_ready, 1'b1);
      check("pp_valid_gap",  bus.out_valid, 1'b0);
      tick();
      bus.wr_valid = 1'b0;
      bus.wr_acc   = 1'b0;
      cap.delete();
      drain();
      check("pp_b_beats", cap.size(), 4);
      if (cap.size() == BEATS) begin
         check("pp_b_row2", cap[0][2], splat(8'h82));
         check("pp_b_row4", cap[1][0], '0);
      end
      wr(15, 1'b0, 1'b1, splat(9));
      cap.delete();
      drain();
      check("pp_c_beats", cap.size(), 4);
      if (cap.size() == BEATS) begin
         check("pp_c_row0",  cap[0][0], splat(5));
         check("pp_c_row15", cap[3][3], splat(9));
      end

      // Spurious starts
      cap.delete();
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      repeat (2) tick();
      check("spur_idle_beats", cap.size(), 0);
      fill_tile(3);
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      tick();
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      repeat (BEATS + 2) tick();
      check("spur_beats", cap.size(), 4);

      // Reset during beat 2
      fill_tile(8'h10);
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_out_valid", bus.out_valid, 1'b0);
      check("mrst_out_data",  bus.out_data,  '0);
      check("mrst_out_ready", bus.out_ready, 1'b0);
      check("mrst_wr_ready",  bus.wr_ready,  1'b1);
      wr(6, 1'b0, 1'b0, splat(8'h66));
      wr(9, 1'b0, 1'b1, splat(8'h99));
      cap.delete();
      drain();
      check("mrst_beats", cap.size(), 4);
      if (cap.size() == BEATS) begin
         check("mrst_row6", cap[1][2], splat(8'h66));
         check("mrst_row9", cap[2][1], splat(8'h99));
         check("mrst_row0", cap[0][0], '0);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.wr_valid  = ($urandom_range(0, 2) != 0);
         bus.wr_row    = row_idx_t'($urandom_range(0, (c % 2) ? N - 1 : 3));
         bus.wr_acc    = $urandom_range(0, 1);
         bus.wr_last   = ($urandom_range(0, 9) == 0);
         for (int e = 0; e < N; e++) bus.wr_data[e] = data_t'($urandom);
         bus.out_start = ($urandom_range(0, 3) == 0);
         rst_n         = ($urandom_range(0, 599) != 0);
         tick();
      end
      rst_n         = 1'b1;
      bus.wr_valid  = 1'b0;
      bus.wr_last   = 1'b0;
      bus.out_start = 1'b0;
      repeat (BEATS + 2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spmm_out_drain.md
Name: spmm_out_drain

Overview:
- Output side of the SpMM accelerator: the counterpart of the 4-rows-per-beat RHS loader.
- Collects result rows produced by the PE array into a ping-pong pair of N×N banks, with optional in-place accumulation for output-stationary passes.
- Streams a completed tile out on `out_data[3:0][N-1:0]`, 4 rows per beat over N/4 beats, using the `out_ready`/`out_start` handshake.

Parameters:
- N, 16: matrix dimension; multiple of 4, ≥4.
- W, 8: element width in bits.
- LANES, 4: rows per output beat; fixed at 4.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: state resets on a posedge where reset==0.
- wr_valid  in  1  result row presented.
- wr_ready  out  1  write bank can accept a row.
- wr_row  in  lgN  row index within the tile.
- wr_acc  in  1  1: add to the stored row; 0: overwrite it.
- wr_last  in  1  final row write of the tile; closes the bank.
- wr_data  in  N×W  row elements.
- out_ready  out  1  a FULL bank is waiting and no drain is in progress.
- out_start  in  1  begin draining; honoured only when out_ready==1.
- out_valid  out  1  out_data carries a beat.
- out_data  out  4×N×W  lane i = tile row 4k+i on beat k.

Behaviour:
- Reset values:
  - bank states both EMPTY; wb=rb=0; beat counter 0.
  - wr_ready=1, out_ready=0, out_valid=0, out_data all 0.
  - Bank array contents are not cleared; row-written masks are cleared.
- Bank states: EMPTY → FILLING (first accepted write) → FULL (write with wr_last) → DRAINING (accepted out_start) → EMPTY (edge of last beat).
- Write pointer wb toggles when wr_last is accepted.
- Read pointer rb toggles when the last beat is sent.
- wr_ready = (bank[wb] is EMPTY or FILLING), computed from registered state only.
- Write accept when wr_valid && wr_ready.
  - Acceptance takes effect at that edge.
  - If wr_valid && !wr_ready: ignored, nothing stored.
- Write semantics:
  - wr_acc=0: store wr_data in row wr_row and set mask[wr_row].
  - wr_acc=1 with mask set: store stored+wr_data elementwise, W-bit modulo 2^W (no saturation).
  - wr_acc=1 with mask clear: treat stored value as 0 (plain store) and set mask.
  - The mask is cleared when the bank leaves DRAINING.
  - Rows never written in a tile drain as 0.
- wr_last may accompany any row, including a repeat.
  - It also performs that row's write.
  - The bank becomes FULL at the same edge.
- out_ready = bank[rb] is FULL && bank[rb] is not DRAINING.
- Drain sequence:
  - out_start at cycle t with out_ready=1 → beats at t+1 … t+N/4, with out_valid=1.
  - Beat k: out_data[i] = row 4k+i of bank[rb].
  - out_data = 0 whenever out_valid=0.
  - out_start while out_ready=0 (including mid-drain) is ignored.
- Simultaneous events:
  - Last drain beat of bank X and a write attempt to X in the same cycle: the write sees X as DRAINING, wr_ready=0, so it is blocked; X is writable the next cycle.
  - Fill completion on one bank in the same cycle as a drain on the other: both proceed independently.
  - out_ready can re-assert the cycle after the last beat, if the other bank is FULL; back-to-back drains have a 1-cycle gap.
- Reset mid-operation (including mid-drain): the next cycle shows reset values; a partial tile is discarded.
- Latency:
  - Row write to visible in drain: it must precede the wr_last edge.
  - wr_last accepted → out_ready=1 the next cycle (if rb points to that bank and it is idle).

Decomposition:
- Shared package spmm_pkg holds:
  - N, W, lgN, dbLgN constants;
  - data_t;
  - bank_state_t enum {EMPTY, FILLING, FULL, DRAINING}.
- One sub-module, spmm_out_bank, instantiated twice. It contains:
  - the N×N data_t array with row-written mask;
  - the write/accumulate port;
  - a 4-row read port addressed by beat index;
  - a mask-clear input.
- Top level holds bank state regs, wb/rb pointers, beat counter, handshake logic and output muxing.

Test Plan (N=16, W=8):
- Reset sequence → wr_ready=1, out_ready=0, out_valid=0, all out_data=0.
- Single tile:
  - Stimulus: write rows r=0..15 with every element r+1, acc=0, wr_last on row 15; then out_start.
  - Response: out_ready=1 the cycle after the row-15 write; 4 beats; beat k lane i elements = 4k+i+1; then out_ready=0.
- Accumulate:
  - Stimulus: row 3 = 10 (acc=0), then row 3 += 250 (acc=1); row 5 written only with acc=1, value 7; row 9 never written.
  - Response: drained row 3 = 4, row 5 = 7, row 9 = 0.
- Ping-pong:
  - Stimulus: fill bank0, start draining it, fill bank1 during the drain, then attempt a third tile.
  - Response: wr_ready=0 for the third tile until the cycle after bank0's last beat; out_ready=1 one cycle after bank0's last beat; bank1 drains its own data.
- Spurious start:
  - Stimulus: out_start with out_ready=0, and again during beat 1 of a drain.
  - Response: no extra beats; exactly 4 beats total.
- Reset mid-drain:
  - Stimulus: reset=0 during beat 2.
  - Response: next cycle out_valid=0, out_data=0, out_ready=0, wr_ready=1; a new tile then drains correctly.
